// File: rtl/btb_predictor.sv
// -----------------------------------------------------------------------------
// btb_predictor
// Direct-mapped branch target buffer with per-entry saturating counters.
// Predicts the next PC for the fetch stage, trains on resolved outcomes from
// EXE, flags mispredictions with the correct next PC, and keeps saturating
// performance statistics.
//
// Ports:
//   Clk_CPU        clock, all state changes on the rising edge
//   rst            asynchronous active-low reset
//   if_pc          PC being fetched
//   pred_taken     lookup hit and predicted taken
//   pred_target    predicted target (0 when not taken)
//   ex_*           resolved control-flow information from EXE
//   flush_all      invalidate the whole table
//   redirect       misprediction, PC must load redirect_pc
//   redirect_pc    correct next PC (0 when no redirect)
//   stat_ctrl      resolved control instruction count (saturating)
//   stat_mispred   redirect count (saturating)
// -----------------------------------------------------------------------------
module btb_predictor #(
   parameter int ENTRIES = 64,
   parameter int PC_W    = 32,
   parameter int CTR_W   = 2,
   parameter int STAT_W  = 32
) (
   input  logic              Clk_CPU,
   input  logic              rst,
   input  logic [PC_W-1:0]   if_pc,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   input  logic              ex_valid,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic              ex_is_branch,
   input  logic              ex_is_jal,
   input  logic              ex_is_jalr,
   input  logic              ex_taken,
   input  logic [PC_W-1:0]   ex_target,
   input  logic              ex_pred_taken,
   input  logic [PC_W-1:0]   ex_pred_target,
   input  logic              flush_all,
   output logic              redirect,
   output logic [PC_W-1:0]   redirect_pc,
   output logic [STAT_W-1:0] stat_ctrl,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};

   // Valid bits and counters are flops so reset/flush act in one cycle;
   // tag/target/kind storage carries no reset.
   logic [ENTRIES-1:0] valid_reg;
   logic [CTR_W-1:0]   ctr_reg    [ENTRIES];
   logic [ENTRIES-1:0] jal_mem;
   logic [TAG_W-1:0]   tag_mem    [ENTRIES];
   logic [PC_W-1:0]    target_mem [ENTRIES];
   logic [STAT_W-1:0]  stat_ctrl_reg;
   logic [STAT_W-1:0]  stat_mispred_reg;

   // ---------------- lookup ----------------
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx      = if_pc[IDX_W+1:2];
   assign if_tag      = if_pc[PC_W-1:IDX_W+2];
   assign if_hit      = valid_reg[if_idx] && (tag_mem[if_idx] == if_tag);
   assign pred_taken  = if_hit && (jal_mem[if_idx] || ctr_reg[if_idx][CTR_W-1]);
   assign pred_target = pred_taken ? target_mem[if_idx] : '0;

   // ---------------- misprediction ----------------
   logic            ctl;
   logic [PC_W-1:0] ex_pc4;
   logic [PC_W-1:0] actual_pc;
   logic [PC_W-1:0] predicted_pc;

   assign ctl          = ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
   assign ex_pc4       = ex_pc + PC_W'(4);
   assign actual_pc    = ex_taken ? ex_target : ex_pc4;
   assign predicted_pc = ex_pred_taken ? ex_pred_target : ex_pc4;

   always_comb begin
      redirect    = 1'b0;
      redirect_pc = '0;
      if (ctl) begin
         if (actual_pc != predicted_pc) begin
            redirect    = 1'b1;
            redirect_pc = actual_pc;
         end
      end else if (ex_valid && ex_pred_taken) begin
         // A non-control instruction was predicted taken: the entry is stale.
         redirect    = 1'b1;
         redirect_pc = ex_pc4;
      end
   end

   // ---------------- update decode ----------------
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic             set_valid;
   logic             clr_valid;
   logic             ctr_we;
   logic [CTR_W-1:0] ctr_next;
   logic             meta_we;    // tag + kind written on allocation
   logic             jal_next;
   logic             tgt_we;
   logic [CTR_W-1:0] ctr_cur;

   assign ex_idx  = ex_pc[IDX_W+1:2];
   assign ex_tag  = ex_pc[PC_W-1:IDX_W+2];
   assign ex_hit  = valid_reg[ex_idx] && (tag_mem[ex_idx] == ex_tag);
   assign ctr_cur = ctr_reg[ex_idx];

   always_comb begin
      set_valid = 1'b0;
      clr_valid = 1'b0;
      ctr_we    = 1'b0;
      ctr_next  = ctr_cur;
      meta_we   = 1'b0;
      jal_next  = 1'b0;
      tgt_we    = 1'b0;
      if (ex_valid && !flush_all) begin
         if (!ctl) begin
            if (ex_pred_taken && ex_hit)
               clr_valid = 1'b1;
         end else if (ex_is_jalr) begin
            if (ex_hit)
               clr_valid = 1'b1;
         end else if (ex_is_jal) begin
            tgt_we = 1'b1;
            if (!ex_hit) begin
               set_valid = 1'b1;
               meta_we   = 1'b1;
               jal_next  = 1'b1;
               ctr_we    = 1'b1;
               ctr_next  = CTR_MAX;
            end
         end else if (ex_hit) begin
            ctr_we = 1'b1;
            if (ex_taken) begin
               tgt_we = 1'b1;
               if (ctr_cur != CTR_MAX)
                  ctr_next = ctr_cur + CTR_W'(1);
            end else if (ctr_cur != '0) begin
               ctr_next = ctr_cur - CTR_W'(1);
            end
         end else if (ex_taken) begin
            set_valid = 1'b1;
            meta_we   = 1'b1;
            jal_next  = 1'b0;
            tgt_we    = 1'b1;
            ctr_we    = 1'b1;
            ctr_next  = CTR_WEAK;
         end
      end
   end

   // ---------------- state ----------------
   always_ff @(posedge Clk_CPU or negedge rst) begin
      if (!rst) begin
         valid_reg        <= '0;
         stat_ctrl_reg    <= '0;
         stat_mispred_reg <= '0;
         for (int i = 0; i < ENTRIES; i++)
            ctr_reg[i] <= '0;
      end else begin
         if (flush_all)
            valid_reg <= '0;
         else if (set_valid)
            valid_reg[ex_idx] <= 1'b1;
         else if (clr_valid)
            valid_reg[ex_idx] <= 1'b0;
         if (ctr_we)
            ctr_reg[ex_idx] <= ctr_next;
         if (ctl && (stat_ctrl_reg != '1))
            stat_ctrl_reg <= stat_ctrl_reg + STAT_W'(1);
         if (redirect && (stat_mispred_reg != '1))
            stat_mispred_reg <= stat_mispred_reg + STAT_W'(1);
      end
   end

   always_ff @(posedge Clk_CPU) begin
      if (meta_we) begin
         tag_mem[ex_idx] <= ex_tag;
         jal_mem[ex_idx] <= jal_next;
      end
      if (tgt_we)
         target_mem[ex_idx] <= ex_target;
   end

   assign stat_ctrl    = stat_ctrl_reg;
   assign stat_mispred = stat_mispred_reg;

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

   localparam int PC_W   = 32;
   localparam int STAT_W = 4;
   localparam logic [STAT_W-1:0] SMAX = '1;

   logic              clk;
   logic              rst;
   logic [PC_W-1:0]   if_pc;
   logic              pred_taken;
   logic [PC_W-1:0]   pred_target;
   logic              ex_valid;
   logic [PC_W-1:0]   ex_pc;
   logic              ex_is_branch;
   logic              ex_is_jal;
   logic              ex_is_jalr;
   logic              ex_taken;
   logic [PC_W-1:0]   ex_target;
   logic              ex_pred_taken;
   logic [PC_W-1:0]   ex_pred_target;
   logic              flush_all;
   logic              redirect;
   logic [PC_W-1:0]   redirect_pc;
   logic [STAT_W-1:0] stat_ctrl;
   logic [STAT_W-1:0] stat_mispred;

   btb_predictor #(.ENTRIES(64), .PC_W(PC_W), .CTR_W(2), .STAT_W(STAT_W)) dut (
      .Clk_CPU(clk), .rst(rst), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
      .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .flush_all(flush_all), .redirect(redirect), .redirect_pc(redirect_pc),
      .stat_ctrl(stat_ctrl), .stat_mispred(stat_mispred)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lpc;
      logic        ev, br, jal, jalr, tk;
      logic [31:0] pc, tgt;
      logic        pt;
      logic [31:0] ptgt;
      logic        fl;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_rd;
      logic [31:0] e_rpc;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vecs[23];

   function automatic vec_t mk(logic [31:0] lpc, logic ev, br, jal, jalr, tk,
                               logic [31:0] pc, tgt, logic pt, logic [31:0] ptgt,
                               logic fl, logic e_pt, logic [31:0] e_ptgt,
                               logic e_rd, logic [31:0] e_rpc);
      vec_t v;
      v.lpc = lpc; v.ev = ev; v.br = br; v.jal = jal; v.jalr = jalr; v.tk = tk;
      v.pc = pc; v.tgt = tgt; v.pt = pt; v.ptgt = ptgt; v.fl = fl;
      v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_rd = e_rd; v.e_rpc = e_rpc;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      if_pc = v.lpc; ex_valid = v.ev; ex_is_branch = v.br; ex_is_jal = v.jal;
      ex_is_jalr = v.jalr; ex_taken = v.tk; ex_pc = v.pc; ex_target = v.tgt;
      ex_pred_taken = v.pt; ex_pred_target = v.ptgt; flush_all = v.fl;
   endtask

   initial begin
      int n_ctl;
      int n_mis;
      vec_t idle;
      n_ctl = 0;
      n_mis = 0;

      //            lpc          ev br j jr tk pc           tgt         pt ptgt        fl e_pt e_ptgt      e_rd e_rpc
      vecs[0]  = mk(32'h40,     0, 0, 0, 0, 0, 32'h0,       32'h0,      0, 32'h0,      0, 0, 32'h0,     0, 32'h0);
      vecs[1]  = mk(32'h100,    1, 1, 0, 0, 1, 32'h100,     32'h80,     0, 32'h0,      0, 0, 32'h0,     1, 32'h80);
      vecs[2]  = mk(32'h100,    1, 1, 0, 0, 1, 32'h100,     32'h80,     1, 32'h80,     0, 1, 32'h80,    0, 32'h0);
      vecs[3]  = mk(32'h100,    1, 1, 0, 0, 1, 32'h100,     32'h80,     1, 32'h80,     0, 1, 32'h80,    0, 32'h0);
      vecs[4]  = mk(32'h100,    1, 1, 0, 0, 0, 32'h100,     32'h80,     1, 32'h80,     0, 1, 32'h80,    1, 32'h104);
      vecs[5]  = mk(32'h100,    1, 1, 0, 0, 0, 32'h100,     32'h80,     1, 32'h80,     0, 1, 32'h80,    1, 32'h104);
      vecs[6]  = mk(32'h100,    1, 1, 0, 0, 0, 32'h100,     32'h80,     0, 32'h0,      0, 0, 32'h0,     0, 32'h0);
      vecs[7]  = mk(32'h100,    1, 1, 0, 0, 1, 32'h100,     32'h80,     0, 32'h0,      0, 0, 32'h0,     1, 32'h80);
      vecs[8]  = mk(32'h100,    1, 1, 0, 0, 1, 32'h100,     32'h80,     0, 32'h0,      0, 0, 32'h0,     1, 32'h80);
      vecs[9]  = mk(32'h100,    0, 0, 0, 0, 0, 32'h0,       32'h0,      0, 32'h0,      0, 1, 32'h80,    0, 32'h0);
      vecs[10] = mk(32'h100,    1, 0, 0, 1, 1, 32'h100,     32'h400,    1, 32'h80,     0, 1, 32'h80,    1, 32'h400);
      vecs[11] = mk(32'h100,    1, 0, 1, 0, 1, 32'h100,     32'h180,    0, 32'h0,      0, 0, 32'h0,     1, 32'h180);
      vecs[12] = mk(32'h100,    1, 1, 0, 0, 1, 32'h200,     32'h280,    0, 32'h0,      0, 1, 32'h180,   1, 32'h280);
      vecs[13] = mk(32'h100,    1, 0, 1, 0, 1, 32'h100,     32'h180,    0, 32'h0,      0, 0, 32'h0,     1, 32'h180);
      vecs[14] = mk(32'h300,    1, 1, 0, 0, 1, 32'h300,     32'h500,    0, 32'h0,      0, 0, 32'h0,     1, 32'h500);
      vecs[15] = mk(32'h300,    1, 0, 0, 0, 0, 32'h300,     32'h0,      1, 32'h500,    0, 1, 32'h500,   1, 32'h304);
      vecs[16] = mk(32'h300,    0, 0, 0, 0, 0, 32'h0,       32'h0,      0, 32'h0,      0, 0, 32'h0,     0, 32'h0);
      vecs[17] = mk(32'h300,    1, 0, 1, 0, 1, 32'h300,     32'h600,    0, 32'h0,      0, 0, 32'h0,     1, 32'h600);
      vecs[18] = mk(32'h300,    1, 1, 0, 0, 1, 32'h340,     32'h700,    0, 32'h0,      1, 1, 32'h600,   1, 32'h700);
      vecs[19] = mk(32'h300,    0, 0, 0, 0, 0, 32'h0,       32'h0,      0, 32'h0,      0, 0, 32'h0,     0, 32'h0);
      vecs[20] = mk(32'h340,    0, 0, 0, 0, 0, 32'h0,       32'h0,      0, 32'h0,      0, 0, 32'h0,     0, 32'h0);
      vecs[21] = mk(32'h0,      1, 1, 0, 0, 0, 32'hFFFFFFFC, 32'h40,    1, 32'h0,      0, 0, 32'h0,     0, 32'h0);
      vecs[22] = mk(32'hFFFFFFFC, 0, 1, 0, 0, 1, 32'h100,   32'h80,     1, 32'h80,     0, 0, 32'h0,     0, 32'h0);

      idle = mk(32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);

      // reset with EXE idle
      drive(idle);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 23; i++) begin
         logic [STAT_W-1:0] e_ctl;
         logic [STAT_W-1:0] e_mis;
         drive(vecs[i]);
         @(negedge clk);
         e_ctl = (n_ctl > int'(SMAX)) ? SMAX : STAT_W'(n_ctl);
         e_mis = (n_mis > int'(SMAX)) ? SMAX : STAT_W'(n_mis);
         chk($sformatf("v%0d pred_taken", i),   32'(pred_taken),   32'(vecs[i].e_pt));
         chk($sformatf("v%0d pred_target", i),  pred_target,       vecs[i].e_ptgt);
         chk($sformatf("v%0d redirect", i),     32'(redirect),     32'(vecs[i].e_rd));
         chk($sformatf("v%0d redirect_pc", i),  redirect_pc,       vecs[i].e_rpc);
         chk($sformatf("v%0d stat_ctrl", i),    32'(stat_ctrl),    32'(e_ctl));
         chk($sformatf("v%0d stat_mispred", i), 32'(stat_mispred), 32'(e_mis));
         $display("vec %0d lpc=%08h ex_pc=%08h pred=%0d/%08h redir=%0d/%08h ctl=%0d mis=%0d",
                  i, vecs[i].lpc, vecs[i].pc, pred_taken, pred_target, redirect,
                  redirect_pc, stat_ctrl, stat_mispred);
         if (vecs[i].ev && (vecs[i].br || vecs[i].jal || vecs[i].jalr)) n_ctl++;
         if (vecs[i].e_rd) n_mis++;
         @(posedge clk);
         #1;
      end

      // 16 control instructions so far: stat_ctrl is pinned at all-ones; 13 redirects.
      drive(mk(32'h0, 1, 0, 1, 0, 1, 32'h100, 32'h180, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0));
      @(negedge clk);
      chk("sat stat_ctrl", 32'(stat_ctrl), 32'h0F);
      chk("h1 redirect", 32'(redirect), 32'h1);
      chk("h1 mispred", 32'(stat_mispred), 32'd13);
      $display("hand jal alloc redir=%0d ctl=%0d mis=%0d", redirect, stat_ctrl, stat_mispred);
      @(posedge clk); #1;

      drive(mk(32'h100, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0));
      @(negedge clk);
      chk("h2 pred_taken", 32'(pred_taken), 32'h1);
      chk("h2 pred_target", pred_target, 32'h180);
      chk("h2 stat_ctrl held", 32'(stat_ctrl), 32'h0F);
      chk("h2 mispred", 32'(stat_mispred), 32'd14);
      $display("hand lookup pred=%0d/%08h ctl=%0d mis=%0d", pred_taken, pred_target, stat_ctrl, stat_mispred);
      @(posedge clk); #1;

      // two stale-entry redirects push stat_mispred to all-ones and beyond
      for (int k = 0; k < 2; k++) begin
         drive(mk(32'h100, 1, 0, 0, 0, 0, 32'h800, 32'h0, 1, 32'h900, 0, 1, 32'h180, 1, 32'h804));
         @(negedge clk);
         chk($sformatf("h3.%0d redirect_pc", k), redirect_pc, 32'h804);
         $display("hand stale %0d redir=%0d/%08h mis=%0d", k, redirect, redirect_pc, stat_mispred);
         @(posedge clk); #1;
      end
      drive(idle);
      if_pc = 32'h100;
      @(negedge clk);
      chk("sat stat_mispred", 32'(stat_mispred), 32'h0F);
      chk("sat stat_ctrl final", 32'(stat_ctrl), 32'h0F);

      // asynchronous reset between edges clears table and stats immediately
      #2 rst = 1'b0;
      #1;
      chk("async rst pred_taken", 32'(pred_taken), 32'h0);
      chk("async rst pred_target", pred_target, 32'h0);
      chk("async rst stat_ctrl", 32'(stat_ctrl), 32'h0);
      chk("async rst stat_mispred", 32'(stat_mispred), 32'h0);
      $display("async reset pred=%0d ctl=%0d mis=%0d", pred_taken, stat_ctrl, stat_mispred);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("post rst lookup", 32'(pred_taken), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
